// File: rtl/vga_letter_sequencer.sv
// Letter sequencer feeding the letter-to-segment colour stage.
// Holds a writable message of 5-bit letter codes, presents the letter for the
// digit currently being scanned (static or scrolling), and generates the
// frame-rate effect controls (valid, shine, ambiant, steady).
module vga_letter_sequencer #(
  parameter int MSG_LEN    = 16,
  parameter int DIGITS     = 4,
  parameter int TICK_DIV   = 25000000,
  parameter int HOLD_TICKS = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [1:0]                mode,
  input  logic                      msg_wr,
  input  logic [4:0]                msg_addr,
  input  logic [4:0]                msg_data,
  input  logic [$clog2(DIGITS)-1:0] digit_sel,
  output logic [4:0]                letter,
  output logic                      valid,
  output logic                      shine,
  output logic                      ambiant,
  output logic                      steady
);

  localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = $clog2(HOLD_TICKS + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [4:0] BLANK = 5'd31;

  logic [4:0]    mem [MSG_LEN];
  logic [1:0]    state;
  logic [1:0]    mode_q;
  logic [AW-1:0] offset;
  logic [AW-1:0] offset_inc;
  logic [CW-1:0] tick_cnt;
  logic [HW-1:0] hold_cnt;
  logic          tick;
  logic          wr_ok;
  logic [AW:0]   idx_sum;
  logic [AW-1:0] idx;
  logic          prev_active;
  logic          prev_fx;

  // Terminal count of the effect/scroll divider; only counts while active.
  assign tick = (state != S_IDLE) && (tick_cnt == CW'(TICK_DIV - 1));

  assign wr_ok = ({1'b0, msg_addr} < 6'(MSG_LEN));

  assign offset_inc = (offset == AW'(MSG_LEN - 1)) ? '0 : offset + 1'b1;

  // Both operands are below MSG_LEN, so one conditional subtract wraps the sum.
  assign idx_sum = {1'b0, offset} + (AW+1)'(digit_sel);
  assign idx     = (idx_sum >= (AW+1)'(MSG_LEN)) ? AW'(idx_sum - (AW+1)'(MSG_LEN))
                                                 : idx_sum[AW-1:0];

  // Effect levels follow mode_q directly so they change in the same cycle.
  assign shine   = (state != S_IDLE) && (mode_q == 2'd2);
  assign ambiant = (state != S_IDLE) && (mode_q == 2'd3);

  // Message storage; blanked on reset, writes outside the message are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MSG_LEN; i++) mem[i] <= BLANK;
    end else if (msg_wr && wr_ok) begin
      mem[msg_addr[AW-1:0]] <= msg_data;
    end
  end

  // Letter lookup, one cycle behind digit_sel; reads see pre-write contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      letter <= BLANK;
    end else if (state == S_IDLE) begin
      letter <= mem[AW'(digit_sel)];
    end else begin
      letter <= mem[idx];
    end
  end

  // valid/steady pulses: steady fires one cycle after IDLE entry or an effect mode ending.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid       <= 1'b0;
      steady      <= 1'b1;
      prev_active <= 1'b0;
      prev_fx     <= 1'b0;
    end else begin
      valid       <= tick;
      steady      <= (prev_active && (state == S_IDLE)) || (prev_fx && !mode_q[1]);
      prev_active <= (state != S_IDLE);
      prev_fx     <= mode_q[1];
    end
  end

  // Sequencer FSM: divider, mode sampling, scroll offset and post-wrap hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      mode_q   <= 2'd0;
      offset   <= '0;
      tick_cnt <= '0;
      hold_cnt <= '0;
    end else if (!en) begin
      state    <= S_IDLE;
      offset   <= '0;
      tick_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_RUN;
          mode_q   <= mode;
          tick_cnt <= '0;
        end
        S_RUN, S_HOLD: begin
          tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
          if (tick) begin
            mode_q <= mode;
            if (state == S_RUN) begin
              if (mode_q == 2'd1) begin
                offset <= offset_inc;
                if (offset_inc == '0) begin
                  state    <= S_HOLD;
                  hold_cnt <= '0;
                end
              end
            end else if (hold_cnt == HW'(HOLD_TICKS - 1)) begin
              state    <= S_RUN;
              hold_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
            // Leaving scroll (to any other mode) restarts the message at the start.
            if ((mode != 2'd1) && (mode != mode_q)) offset <= '0;
          end
        end
        default: begin
          state    <= S_IDLE;
          offset   <= '0;
          tick_cnt <= '0;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_letter_sequencer.sv
// Bench for vga_letter_sequencer: cycle model derived from the behavioural
// rules plus directed literal expectations.
module tb_vga_letter_sequencer;

  localparam int MSG_LEN    = 8;
  localparam int DIGITS     = 4;
  localparam int TICK_DIV   = 4;
  localparam int HOLD_TICKS = 2;

  logic       clk = 1'b0;
  logic       rst, en, msg_wr;
  logic [1:0] mode;
  logic [4:0] msg_addr, msg_data;
  logic [1:0] digit_sel;
  logic [4:0] letter;
  logic       valid, shine, ambiant, steady;

  int n_chk  = 0;
  int n_fail = 0;

  vga_letter_sequencer #(
    .MSG_LEN(MSG_LEN), .DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .HOLD_TICKS(HOLD_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .msg_wr(msg_wr),
    .msg_addr(msg_addr), .msg_data(msg_data), .digit_sel(digit_sel),
    .letter(letter), .valid(valid), .shine(shine), .ambiant(ambiant), .steady(steady)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_mem [MSG_LEN];
  int m_active, m_cnt, m_mode, m_off, m_hold, m_pend, m_nm;
  int exp_letter, exp_valid, exp_steady;
  bit m_tk, m_last_tick, chk_on;

  initial chk_on = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MSG_LEN; i++) m_mem[i] = 31;
      m_active = 0; m_cnt = 0; m_mode = 0; m_off = 0; m_hold = 0; m_pend = 0;
      exp_letter = 31; exp_valid = 0; exp_steady = 1;
      m_last_tick = 1'b0;
      chk_on = 1'b1;
    end else begin
      m_tk = (m_active != 0) && (m_cnt == TICK_DIV - 1);
      m_last_tick = m_tk;
      exp_letter = m_mem[(m_active != 0) ? (m_off + int'(digit_sel)) % MSG_LEN : int'(digit_sel)];
      exp_valid  = int'(m_tk);
      exp_steady = m_pend;
      m_pend = 0;
      if (msg_wr && int'(msg_addr) < MSG_LEN) m_mem[msg_addr] = int'(msg_data);
      if (!en) begin
        if (m_active != 0) m_pend = 1;
        m_active = 0; m_cnt = 0; m_off = 0; m_hold = 0;
      end else if (m_active == 0) begin
        m_active = 1; m_cnt = 0;
        m_nm = int'(mode);
        if (m_mode >= 2 && m_nm < 2) m_pend = 1;
        m_mode = m_nm;
      end else begin
        m_cnt = (m_cnt + 1) % TICK_DIV;
        if (m_tk) begin
          m_nm = int'(mode);
          if (m_hold > 0) m_hold--;
          else if (m_mode == 1) begin
            m_off = (m_off + 1) % MSG_LEN;
            if (m_off == 0) m_hold = HOLD_TICKS;
          end
          if (m_nm != 1 && m_nm != m_mode) m_off = 0;
          if (m_mode >= 2 && m_nm < 2) m_pend = 1;
          m_mode = m_nm;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_letter",  int'(letter),  exp_letter);
      chk("model_valid",   int'(valid),   exp_valid);
      chk("model_steady",  int'(steady),  exp_steady);
      chk("model_shine",   int'(shine),   int'(m_active != 0 && m_mode == 2));
      chk("model_ambiant", int'(ambiant), int'(m_active != 0 && m_mode == 3));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input int a, input int d);
    msg_wr = 1'b1; msg_addr = 5'(a); msg_data = 5'(d);
    step();
    msg_wr = 1'b0;
  endtask

  task automatic wait_tick();
    int g;
    g = 0;
    do begin
      step();
      g++;
    end while (!m_last_tick && g < 50);
    chk("tick_wait", int'(m_last_tick), 1);
  endtask

  task automatic tick_read(input string name, input int d, input int e);
    if (!m_last_tick) wait_tick();
    digit_sel = 2'(d);
    step();
    chk(name, int'(letter), e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int nv;
    rst = 1'b1; en = 1'b0; mode = 2'd0; msg_wr = 1'b0;
    msg_addr = 5'd0; msg_data = 5'd0; digit_sel = 2'd0;
    step(); step();
    chk("rst_steady", int'(steady), 1);
    chk("rst_letter", int'(letter), 31);
    chk("rst_valid",  int'(valid),  0);
    chk("rst_shine",  int'(shine),  0);
    rst = 1'b0;
    step();
    chk("post_rst_steady", int'(steady), 0);
    for (int d = 0; d < 4; d++) begin
      digit_sel = 2'(d); step();
      chk("blank_letter", int'(letter), 31);
    end

    // Static display
    for (int i = 0; i < MSG_LEN; i++) wr(i, i);
    en = 1'b1; mode = 2'd0;
    step();
    for (int d = 0; d < 4; d++) begin
      digit_sel = 2'(d); step();
      chk("static_letter", int'(letter), d);
    end
    nv = 0;
    repeat (16) begin step(); nv += int'(valid); end
    chk("valid_count_16cyc", nv, 4);

    // Scroll
    mode = 2'd1;
    wait_tick();
    tick_read("scroll_d0", 0, 0);
    for (int i = 1; i < MSG_LEN; i++) begin
      tick_read("scroll_d0", 0, i);
      if (i == 6) begin
        digit_sel = 2'd1; step(); chk("wrap_d1", int'(letter), 7);
        digit_sel = 2'd2; step(); chk("wrap_d2", int'(letter), 0);
        digit_sel = 2'd3; step(); chk("wrap_d3", int'(letter), 1);
      end
    end
    tick_read("wrap_to_0", 0, 0);
    tick_read("hold_1", 0, 0);
    tick_read("hold_2", 0, 0);
    tick_read("resume_1", 0, 1);

    // Writes during scroll (offset 1)
    wr(9, 5);
    msg_wr = 1'b1; msg_addr = 5'd2; msg_data = 5'd19; digit_sel = 2'd1;
    step();
    msg_wr = 1'b0;
    chk("same_cycle_old", int'(letter), 2);
    digit_sel = 2'd0; step();
    chk("oob_no_alias", int'(letter), 1);
    step();
    chk("new_data_19", int'(letter), 19);

    // Deassert en at offset 5
    tick_read("scroll_d0", 0, 3);
    tick_read("scroll_d0", 0, 4);
    tick_read("scroll_d0", 0, 5);
    en = 1'b0; digit_sel = 2'd2;
    step();
    chk("idle_entry_letter", int'(letter), 7);
    chk("idle_entry_steady", int'(steady), 0);
    step();
    chk("idle_steady_pulse", int'(steady), 1);
    chk("idle_letter_19",    int'(letter), 19);
    step();
    chk("idle_steady_end", int'(steady), 0);
    chk("idle_valid",      int'(valid),  0);
    en = 1'b1; mode = 2'd0;
    step();
    digit_sel = 2'd1; step();
    chk("offset_cleared", int'(letter), 1);
    step(); step();
    chk("cnt_cleared_v0", int'(valid), 0);
    step();
    chk("cnt_cleared_v1", int'(valid), 1);

    // Shine then back to static
    mode = 2'd2;
    chk("shine_before", int'(shine), 0);
    wait_tick();
    chk("shine_on", int'(shine), 1);
    mode = 2'd0;
    wait_tick();
    chk("shine_off",    int'(shine),  0);
    chk("shine_st_pre", int'(steady), 0);
    step();
    chk("shine_st_pulse", int'(steady), 1);
    step();
    chk("shine_st_end", int'(steady), 0);

    // Ambiant then back to static
    mode = 2'd3;
    chk("amb_before", int'(ambiant), 0);
    wait_tick();
    chk("amb_on",       int'(ambiant), 1);
    chk("amb_no_shine", int'(shine),   0);
    mode = 2'd0;
    wait_tick();
    chk("amb_off",    int'(ambiant), 0);
    chk("amb_st_pre", int'(steady),  0);
    step();
    chk("amb_st_pulse", int'(steady), 1);
    step();
    chk("amb_st_end", int'(steady), 0);

    // Reset while running
    mode = 2'd2;
    wait_tick();
    rst = 1'b1;
    step();
    chk("rst_run_letter",  int'(letter),  31);
    chk("rst_run_valid",   int'(valid),   0);
    chk("rst_run_shine",   int'(shine),   0);
    chk("rst_run_ambiant", int'(ambiant), 0);
    chk("rst_run_steady",  int'(steady),  1);
    rst = 1'b0; en = 1'b0;
    step();
    for (int d = 0; d < 4; d++) begin
      digit_sel = 2'(d); step();
      chk("reblank_letter", int'(letter), 31);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_letter_sequencer.md
Name: vga_letter_sequencer

Overview:
Upstream feeder for the letter-to-segment colour stage. Holds a writable message of 5-bit letter codes and produces the letter code for the digit the VGA scanner is currently drawing, in static or scrolling form. Generates the frame-rate effect controls (valid, shine, ambiant, steady) that drive the downstream colour animation. Sits between the game/menu control logic and the letter-to-segment stage.

Parameters:
MSG_LEN, 16, message length in letters (2..32); DIGITS must be <= MSG_LEN
DIGITS, 4, number of on-screen letter positions
TICK_DIV, 25000000, clk cycles per effect/scroll tick (>= 2)
HOLD_TICKS, 3, ticks to pause after a full scroll wrap

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
en  input  1  run enable; 0 forces IDLE
mode  input  2  0 static, 1 scroll, 2 shine, 3 ambiant
msg_wr  input  1  message write strobe
msg_addr  input  5  write index
msg_data  input  5  letter code to write
digit_sel  input  $clog2(DIGITS)  digit position being drawn (0 = leftmost)
letter  output  5  letter code for digit_sel
valid  output  1  one-cycle tick pulse to colour stage
shine  output  1  shine effect level
ambiant  output  1  ambiant effect level
steady  output  1  one-cycle restore-default-colour pulse

Behaviour:
- One clock domain (clk); reset is synchronous and active-high (rst); all state updates on posedge clk.
- Reset values: letter=5'd31 (blank, renders background); valid=0; shine=0; ambiant=0; steady=1; offset=0; tick counter=0; hold counter=0; mode_q=0; state=IDLE; every message entry=5'd31.
- Message RAM: MSG_LEN x 5 bits. Write on msg_wr when msg_addr < MSG_LEN; out-of-range writes are ignored. Writes are accepted in every state. A write and a read of the same entry in the same cycle returns the old data.
- Tick counter: counts 0..TICK_DIV-1 only while state != IDLE. tick=1 on the terminal count; the counter then wraps to 0. The counter is cleared to 0 on entry to IDLE.
- valid: registered copy of tick (one cycle wide, one cycle after the terminal count).
- mode_q: mode is sampled into mode_q only on tick, or on the IDLE->RUN transition.
- FSM states:
  - IDLE: entered from any state when en=0 (or on reset).
  - RUN: entered from IDLE when en=1.
  - HOLD: entered from RUN on a tick when mode_q=1 and the offset wraps to 0.
  - HOLD->RUN after HOLD_TICKS ticks.
  - en=0 in any state -> IDLE on the next cycle.
- Offset:
  - Advances by 1 on each tick in RUN when mode_q=1, wrapping MSG_LEN-1 -> 0.
  - Frozen in HOLD.
  - Cleared to 0 when mode_q changes to a value other than 1 and on IDLE entry.
- letter: registered, 1-cycle latency from digit_sel.
  - idx = offset + digit_sel; if idx >= MSG_LEN then idx -= MSG_LEN (single conditional subtract suffices).
  - letter = mem[idx].
  - In IDLE, letter = mem[digit_sel].
- Effect outputs:
  - shine = (state != IDLE && mode_q==2).
  - ambiant = (state != IDLE && mode_q==3).
  - Both levels update in the same cycle as mode_q.
- steady: one-cycle pulse in the cycle after any of:
  - entry to IDLE;
  - mode_q changing from 2 or 3 to 0 or 1;
  - reset release (reset value 1, cleared one cycle later unless retriggered).
  - Simultaneous triggers produce a single pulse.
- Reset mid-operation: the restart is full; the message is re-blanked.

Test Plan:
- Params MSG_LEN=8, DIGITS=4, TICK_DIV=4, HOLD_TICKS=2 for all scenarios. rst 2 cycles, then en=0 -> letter=31 for all digit_sel; steady=1 in the first cycle, then 0; shine=ambiant=valid=0.
- Write mem[0..7]=0..7; en=1, mode=0; sweep digit_sel 0..3 -> letter 0,1,2,3 with 1-cycle latency. valid pulses every 4 cycles; offset stays 0.
- mode=1, run 8 ticks -> on-screen digit 0 shows 0,1,...,7. When offset=6, digits read 6,7,0,1 (wrap). After the wrap to 0 the FSM enters HOLD: offset=0 for 2 ticks, then resumes at 1.
- mode=2 then mode=0 -> shine goes 1 at the next tick and 0 at the tick after mode=0; steady pulses exactly once, one cycle after shine falls. Same sequence with mode=3 checks ambiant.
- Write msg_addr=9 (out of range), then msg_addr=2 with data=5'd19 during scroll -> mem unchanged for 9; letter shows 19 wherever idx=2. Same-cycle read of addr 2 returns the old value.
- Deassert en mid-scroll at offset=5 -> next cycle state=IDLE, offset=0, tick counter=0, steady=1 for one cycle, valid silent. Assert rst while in RUN -> all outputs at reset values, all entries blank.
